// File: rtl/linear_pkg.sv
// Shared types and widths for the linear (fully-connected) datapath.
package linear_pkg;

    localparam int unsigned ACC_W   = 32;
    localparam int unsigned PROD_W  = 48;
    localparam int unsigned ZP_W    = 8;
    localparam int unsigned MULT_W  = 16;
    localparam int unsigned SHIFT_W = 5;

    typedef enum logic [1:0] {
        ACCUM,
        CORRECT,
        SCALE,
        HOLD
    } acc_state_t;

endpackage

// File: rtl/requant_stage.sv
// Registered requantization: signed multiply by an unsigned multiplier, rounding
// arithmetic right shift (round half up) and clamp to an unsigned OUT_W-bit range.
module requant_stage
    import linear_pkg::*;
#(
    parameter int unsigned OUT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [ACC_W-1:0]   corr,
    input  logic [MULT_W-1:0]  mult,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   out_data
);

    // One guard bit above PROD_W so the rounding add can never overflow.
    localparam int unsigned EXT_W = PROD_W + 1;
    localparam logic signed [EXT_W-1:0] MaxVal = EXT_W'((64'd1 << OUT_W) - 64'd1);

    logic signed [EXT_W-1:0] corr_ext;
    logic signed [EXT_W-1:0] mult_ext;
    logic signed [EXT_W-1:0] prod;
    logic signed [EXT_W-1:0] half;
    logic signed [EXT_W-1:0] rnd;
    logic [OUT_W-1:0]        clamped;
    logic [OUT_W-1:0]        out_data_q;

    always_comb begin
        corr_ext = {{(EXT_W - ACC_W){corr[ACC_W-1]}}, corr};
        mult_ext = {{(EXT_W - MULT_W){1'b0}}, mult};
        prod     = corr_ext * mult_ext;
        half     = '0;
        if (shift != '0) begin
            half[shift - SHIFT_W'(1)] = 1'b1;
        end
        rnd = (prod + half) >>> shift;
        if (rnd[EXT_W-1]) begin
            clamped = '0;
        end else if (rnd > MaxVal) begin
            clamped = '1;
        end else begin
            clamped = rnd[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
        end else if (load) begin
            out_data_q <= clamped;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: rtl/linear_accumulator.sv
// Accumulates BEATS multiplier beats into one neuron, applies zero-point and bias
// correction, requantizes and presents the activation on a valid/ready output.
module linear_accumulator
    import linear_pkg::*;
#(
    parameter int unsigned BEATS = 4,
    parameter int unsigned OUT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    input  logic [ACC_W-1:0]   in_ai,
    input  logic [ZP_W-1:0]    w_zp,
    input  logic [ACC_W-1:0]   bias,
    input  logic [MULT_W-1:0]  mult,
    input  logic [SHIFT_W-1:0] shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data
);

    localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

    acc_state_t         state_q, state_d;
    logic [CntW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [ACC_W-1:0]   sum_acc_q, sum_acc_d;
    logic [ACC_W-1:0]   sum_ai_q, sum_ai_d;
    logic [ZP_W-1:0]    w_zp_q, w_zp_d;
    logic [ACC_W-1:0]   bias_q, bias_d;
    logic [MULT_W-1:0]  mult_q, mult_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [ACC_W-1:0]   corr_q, corr_d;
    logic               out_valid_q, out_valid_d;
    logic               rq_load;
    logic [ACC_W-1:0]   zp_prod;

    // Truncation to ACC_W is intended: the correction is defined modulo 2^32.
    assign zp_prod = {{(ACC_W - ZP_W){1'b0}}, w_zp_q} * sum_ai_q;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        sum_acc_d   = sum_acc_q;
        sum_ai_d    = sum_ai_q;
        w_zp_d      = w_zp_q;
        bias_d      = bias_q;
        mult_d      = mult_q;
        shift_d     = shift_q;
        corr_d      = corr_q;
        out_valid_d = out_valid_q;
        rq_load     = 1'b0;

        unique case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    sum_acc_d = sum_acc_q + in_acc;
                    sum_ai_d  = sum_ai_q + in_ai;
                    if (beat_cnt_q == LastBeat) begin
                        beat_cnt_d = '0;
                        w_zp_d     = w_zp;
                        bias_d     = bias;
                        mult_d     = mult;
                        shift_d    = shift;
                        state_d    = CORRECT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CntW'(1);
                    end
                end
            end
            CORRECT: begin
                corr_d  = sum_acc_q - zp_prod + bias_q;
                state_d = SCALE;
            end
            SCALE: begin
                rq_load     = 1'b1;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    sum_acc_d   = '0;
                    sum_ai_d    = '0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            beat_cnt_q  <= '0;
            sum_acc_q   <= '0;
            sum_ai_q    <= '0;
            w_zp_q      <= '0;
            bias_q      <= '0;
            mult_q      <= '0;
            shift_q     <= '0;
            corr_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            sum_acc_q   <= sum_acc_d;
            sum_ai_q    <= sum_ai_d;
            w_zp_q      <= w_zp_d;
            bias_q      <= bias_d;
            mult_q      <= mult_d;
            shift_q     <= shift_d;
            corr_q      <= corr_d;
            out_valid_q <= out_valid_d;
        end
    end

    requant_stage #(
        .OUT_W(OUT_W)
    ) u_requant (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (rq_load),
        .corr    (corr_q),
        .mult    (mult_q),
        .shift   (shift_q),
        .out_data(out_data)
    );

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;

endmodule

// File: doc/linear_accumulator.md
# linear_accumulator

Post-multiplier stage of the linear (fully-connected) datapath, fed directly by the vector multiplier. It accumulates the per-beat dot-product partial (`in_acc`) and feature sum (`in_ai`) over `BEATS` consecutive beats that together form one output neuron. It then applies the weight zero-point correction and the bias, requantizes with a fixed-point multiplier and a rounding right shift, and clamps to an unsigned `OUT_W`-bit activation. The result is presented on a valid/ready output towards the activation buffer.

## Interface
- `BEATS`, 4: NP-wide beats per output neuron (≥1).
- `OUT_W`, 8: output activation width (≤16).
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a beat is presented on `in_acc`/`in_ai`.
- `in_ready` out 1: the block accepts the beat. Equal to (state==ACCUM).
- `in_acc` in 32: per-beat Σ feature·weight, unsigned.
- `in_ai` in 32: per-beat Σ feature, unsigned.
- `w_zp` in 8: weight zero point, unsigned.
- `bias` in 32: signed bias.
- `mult` in 16: unsigned requant multiplier.
- `shift` in 5: requant right shift, 0..31.
- `out_valid` out 1: a result is held on `out_data`.
- `out_ready` in 1: the consumer accepts the result.
- `out_data` out OUT_W: unsigned clamped activation.

## Operation
- FSM states: ACCUM → CORRECT → SCALE → HOLD → ACCUM.
- **ACCUM**
  - Each handshake (`in_valid && in_ready`) adds to two registers: `sum_acc += in_acc`, `sum_ai += in_ai`. Both wrap modulo 2^32.
  - `beat_cnt` counts 0..BEATS-1.
  - On the handshake where `beat_cnt == BEATS-1`, the block latches `w_zp`, `bias`, `mult` and `shift` into config registers, clears `beat_cnt`, and goes to CORRECT.
  - Config inputs are don't-care at all other times.
- **CORRECT**
  - `corr = sum_acc - w_zp*sum_ai + bias`, computed modulo 2^32 and registered as a signed 32-bit value.
  - Next state: SCALE.
- **SCALE**
  - `prod = corr * mult`, a 48-bit signed product (`mult` zero-extended).
  - If `shift > 0`: `rnd = (prod + 2^(shift-1)) >>> shift`, an arithmetic shift (round half up).
  - If `shift == 0`: `rnd = prod`.
  - Clamp `rnd` to [0, 2^OUT_W-1].
  - Register the clamped value into `out_data`, set `out_valid = 1`, go to HOLD.
- **HOLD**
  - `out_valid` and `out_data` stay stable until `out_ready` is seen.
  - On `out_valid && out_ready`: clear `out_valid`, clear `sum_acc` and `sum_ai`, go to ACCUM.
  - `out_data` keeps its last value after the handshake.
- `in_ready` is 0 in CORRECT, SCALE and HOLD. Upstream stalls there; no beat is dropped or double-counted.
- `in_valid` while `in_ready = 0` has no effect.
- `BEATS == 1`: every accepted beat goes straight to CORRECT.
- **Reset values:** state ACCUM (so `in_ready = 1`), `out_valid = 0`, `out_data = 0`, all sums, counters and config registers 0.
- Reset asserted mid-operation (any state) discards the partial neuron entirely.

## Timing
- Last beat accepted at edge E0.
- `corr` registered at E1.
- `out_data`/`out_valid` registered at E2. `out_valid` is visible in the cycle after E2.
- Latency from last beat to result: 3 cycles.
- Minimum period per neuron: BEATS + 3 cycles. This assumes `out_ready` is already high when `out_valid` rises, so the output handshake completes in the first HOLD cycle.
- `in_ready` rises in the cycle after the output handshake edge.
- Upstream keeps `in_acc`/`in_ai` stable while `in_valid && !in_ready`.
- No combinational path from `out_ready` to `in_ready`; `in_ready` depends only on the registered state.

## Structure
- Shared package `linear_pkg`:
  - `acc_state_t` enum {ACCUM, CORRECT, SCALE, HOLD}
  - `ACC_W = 32`
  - `PROD_W = 48`
  - `ZP_W = 8`
  - `MULT_W = 16`
  - `SHIFT_W = 5`
- Sub-module `requant_stage`: the registered multiply, round, shift and clamp of SCALE, parameterized by `OUT_W`. It is reused later by the conv path.
- Top holds the FSM, the beat counter, both accumulators, the config latch and the CORRECT register.

## Test plan
- **Basic result** (BEATS=4):
  - Stimulus: `in_acc` 10,20,30,40; `in_ai` 1,2,3,4; `w_zp`=2, `bias`=5, `mult`=1, `shift`=0.
  - Response: `out_data` = 85. `out_valid` rises 3 cycles after the 4th beat. `in_ready` is 0 meanwhile.
- **Rounding:**
  - Stimulus: same beats with `mult`=3, `shift`=2 (prod 255).
  - Response: `out_data` = 64.
- **Clamping:**
  - Stimulus (high): `in_acc` sum 1000, `w_zp`=0, `bias`=0, `mult`=1, `shift`=0. Response: 255.
  - Stimulus (low): `sum_acc` 0, `sum_ai` 10, `w_zp`=5, `bias`=0. Response: 0.
- **Backpressure:**
  - Stimulus: hold `out_ready` low 5 cycles, keep `in_valid` high with new beats.
  - Response: `out_valid` and `out_data` stable, `in_ready` 0, no beat absorbed. After the handshake, `in_ready` = 1 the next cycle and the next neuron equals its standalone value.
- **Reset mid-neuron:**
  - Stimulus: pull `rst_n` low asynchronously after 2 beats.
  - Response: `out_valid` = 0 and `out_data` = 0 immediately. Four fresh beats (10,20,30,40 / 1,2,3,4, same config) give 85, unaffected by the discarded beats.
- **Config latch:**
  - Stimulus: change `bias` from 5 to 100 on the cycle after the last beat.
  - Response: result still 85.
